cl2_pl_exu_wbck: RTL and testbench
==================================

// Module: cl2_pl_exu_wbck
// PURPOSE
//  Write-back arbiter and scoreboard feeding the pipeline register file write port (wd_wen/wd_idx/wd_dat).
//  - Merges results from ALU (single-cycle), LSU and MDU (multi-cycle) into one registered write per cycle.
//  - Tracks destinations of issued long-latency ops so decode can stall on RAW hazards.
//  - Sits between the EXU result sources and the register file; its write outputs connect directly to the regfile write port.
// PARAMETERS
//  XLEN    `CL2_XLEN            data width
//  REG_AW  `CL2_REGFILE_WIDTH   register index width
//  REG_NUM `CL2_REGFILE_NUM     number of architectural registers (x0 hardwired zero)
// PORTS
//  clk_i          in   1       clock
//  rst_n_i        in   1       asynchronous active-low reset
//  alu_vld_i      in   1       ALU result valid (always accepted, no ready)
//  alu_idx_i      in   REG_AW  ALU destination index
//  alu_dat_i      in   XLEN    ALU result
//  lsu_vld_i      in   1       LSU load result valid
//  lsu_rdy_o      out  1       LSU result accepted this cycle
//  lsu_idx_i      in   REG_AW  LSU destination index
//  lsu_dat_i      in   XLEN    LSU load data
//  mdu_vld_i      in   1       MDU result valid
//  mdu_rdy_o      out  1       MDU result accepted this cycle
//  mdu_idx_i      in   REG_AW  MDU destination index
//  mdu_dat_i      in   XLEN    MDU result
//  iss_vld_i      in   1       long-latency (LSU/MDU) op issued with a destination
//  iss_idx_i      in   REG_AW  destination of issued op
//  rs1_idx_i      in   REG_AW  decode source 1 index
//  rs2_idx_i      in   REG_AW  decode source 2 index
//  rs1_busy_o     out  1       rs1 has pending write; decode must stall
//  rs2_busy_o     out  1       rs2 has pending write; decode must stall
//  rs1_fwd_vld_o  out  1       rs1 bypass valid (CL2_WBCK_BYPASS_EN only)
//  rs1_fwd_dat_o  out  XLEN    rs1 bypass data
//  rs2_fwd_vld_o  out  1       rs2 bypass valid
//  rs2_fwd_dat_o  out  XLEN    rs2 bypass data
//  wd_wen_o       out  1       regfile write enable (registered)
//  wd_idx_o       out  REG_AW  regfile write index (registered)
//  wd_dat_o       out  XLEN    regfile write data (registered)
// BEHAVIOUR
//  - Reset: wd_wen_o=0, wd_idx_o=0, wd_dat_o=0, scoreboard pend[] all 0; all busy/fwd outputs 0.
//  - Fixed priority ALU > LSU > MDU; one winner per cycle. lsu_rdy_o = lsu_vld_i & ~alu_vld_i;
//    mdu_rdy_o = mdu_vld_i & ~alu_vld_i & ~lsu_vld_i. Losers hold vld/idx/dat stable until rdy.
//  - Winner registered: wd_* updated at next edge; latency 1 cycle from accept to wd_wen_o.
//  - Winner with idx 0: accepted (rdy high) but wd_wen_o=0 next cycle; wd_idx_o/wd_dat_o may update.
//  - No winner: wd_wen_o=0, wd_idx_o/wd_dat_o hold.
//  - Scoreboard: pend[iss_idx_i] set on iss_vld_i (idx!=0); pend[idx] cleared when LSU/MDU result for idx accepted.
//    Same idx set and clear same cycle: set wins. pend[0] constant 0. ALU writes never touch pend.
//  - rsN_busy_o = (idx!=0) & (pend[idx] | (without macro) wd_wen_o & wd_idx_o==idx).
//  - Async reset mid-operation: pending ops discarded, pend[] cleared, in-flight write dropped.
// CONFIGURATION
//  CL2_WBCK_BYPASS_EN defined: rsN_fwd_vld_o = wd_wen_o & wd_idx_o==rsN_idx_i & rsN_idx_i!=0,
//    rsN_fwd_dat_o = wd_dat_o; registered write does not contribute to busy.
//  Not defined: fwd_vld_o tied 0, fwd_dat_o tied 0; registered write counts as busy (one extra stall cycle).
// TESTING
//  - ALU vld idx=5 dat=0xDEADBEEF -> next cycle wd_wen_o=1, wd_idx_o=5, wd_dat_o=0xDEADBEEF.
//  - ALU, LSU(idx 6), MDU(idx 7) all vld -> ALU cycle 1, LSU cycle 2, MDU cycle 3; rdy pulses once each.
//  - iss idx=9, then rs1_idx=9 -> rs1_busy_o=1 until LSU result idx 9 accepted; 0 after (plus 1 cycle if no bypass).
//  - iss idx=3 same cycle MDU idx=3 accepted -> pend[3] stays 1; writes to idx 0 -> wd_wen_o never 1.
//  - BYPASS_EN: wd_wen_o idx=4 dat=0x1234, rs2_idx=4 -> rs2_fwd_vld_o=1, dat 0x1234, rs2_busy_o=0.
//  - Assert rst_n_i with pend[2]=1 and write in flight -> wd_wen_o=0, rs1_busy_o(idx 2)=0 immediately.

Source files
------------

// File: rtl/cl2_pl_exu_wbck.sv
`default_nettype none
// ============================================================================
// cl2_pl_exu_wbck : write-back arbiter (ALU > LSU > MDU) and RAW scoreboard.
// Optional feature macro: CL2_WBCK_BYPASS_EN. Rev 1.0
// ============================================================================
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif
`ifndef CL2_REGFILE_NUM
`define CL2_REGFILE_NUM 32
`endif

module cl2_pl_exu_wbck #(
  parameter int XLEN    = `CL2_XLEN,
  parameter int REG_AW  = `CL2_REGFILE_WIDTH,
  parameter int REG_NUM = `CL2_REGFILE_NUM
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              alu_vld_i,
  input  logic [REG_AW-1:0] alu_idx_i,
  input  logic [XLEN-1:0]   alu_dat_i,
  input  logic              lsu_vld_i,
  output logic              lsu_rdy_o,
  input  logic [REG_AW-1:0] lsu_idx_i,
  input  logic [XLEN-1:0]   lsu_dat_i,
  input  logic              mdu_vld_i,
  output logic              mdu_rdy_o,
  input  logic [REG_AW-1:0] mdu_idx_i,
  input  logic [XLEN-1:0]   mdu_dat_i,
  input  logic              iss_vld_i,
  input  logic [REG_AW-1:0] iss_idx_i,
  input  logic [REG_AW-1:0] rs1_idx_i,
  input  logic [REG_AW-1:0] rs2_idx_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              rs1_fwd_vld_o,
  output logic [XLEN-1:0]   rs1_fwd_dat_o,
  output logic              rs2_fwd_vld_o,
  output logic [XLEN-1:0]   rs2_fwd_dat_o,
  output logic              wd_wen_o,
  output logic [REG_AW-1:0] wd_idx_o,
  output logic [XLEN-1:0]   wd_dat_o
);

  logic               w_win_vld;
  logic [REG_AW-1:0]  w_win_idx;
  logic [XLEN-1:0]    w_win_dat;
  logic [REG_NUM-1:0] pend_q, pend_d;
  logic               wd_wen_q;
  logic [REG_AW-1:0]  wd_idx_q;
  logic [XLEN-1:0]    wd_dat_q;
  logic               w_rs1_wb_hit, w_rs2_wb_hit;

  assign lsu_rdy_o = lsu_vld_i & ~alu_vld_i;
  assign mdu_rdy_o = mdu_vld_i & ~alu_vld_i & ~lsu_vld_i;

  always_comb begin
    w_win_vld = alu_vld_i | lsu_vld_i | mdu_vld_i;
    w_win_idx = mdu_idx_i;
    w_win_dat = mdu_dat_i;
    if (alu_vld_i) begin
      w_win_idx = alu_idx_i;
      w_win_dat = alu_dat_i;
    end else if (lsu_vld_i) begin
      w_win_idx = lsu_idx_i;
      w_win_dat = lsu_dat_i;
    end
  end

  // Issue is applied after the clears so a same-cycle set on the same index wins.
  always_comb begin
    pend_d = pend_q;
    if (lsu_rdy_o) pend_d[lsu_idx_i] = 1'b0;
    if (mdu_rdy_o) pend_d[mdu_idx_i] = 1'b0;
    if (iss_vld_i) pend_d[iss_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q   <= '0;
      wd_wen_q <= 1'b0;
      wd_idx_q <= '0;
      wd_dat_q <= '0;
    end else begin
      pend_q   <= pend_d;
      wd_wen_q <= w_win_vld & (w_win_idx != '0);
      if (w_win_vld) begin
        wd_idx_q <= w_win_idx;
        wd_dat_q <= w_win_dat;
      end
    end
  end

  assign wd_wen_o = wd_wen_q;
  assign wd_idx_o = wd_idx_q;
  assign wd_dat_o = wd_dat_q;

  assign w_rs1_wb_hit = wd_wen_q & (wd_idx_q == rs1_idx_i);
  assign w_rs2_wb_hit = wd_wen_q & (wd_idx_q == rs2_idx_i);

`ifdef CL2_WBCK_BYPASS_EN
  assign rs1_busy_o    = (rs1_idx_i != '0) & pend_q[rs1_idx_i];
  assign rs2_busy_o    = (rs2_idx_i != '0) & pend_q[rs2_idx_i];
  assign rs1_fwd_vld_o = w_rs1_wb_hit & (rs1_idx_i != '0);
  assign rs2_fwd_vld_o = w_rs2_wb_hit & (rs2_idx_i != '0);
  assign rs1_fwd_dat_o = wd_dat_q;
  assign rs2_fwd_dat_o = wd_dat_q;
`else
  // Without bypass the write sitting in wd_* is not yet visible in the regfile.
  assign rs1_busy_o    = (rs1_idx_i != '0) & (pend_q[rs1_idx_i] | w_rs1_wb_hit);
  assign rs2_busy_o    = (rs2_idx_i != '0) & (pend_q[rs2_idx_i] | w_rs2_wb_hit);
  assign rs1_fwd_vld_o = 1'b0;
  assign rs2_fwd_vld_o = 1'b0;
  assign rs1_fwd_dat_o = '0;
  assign rs2_fwd_dat_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cl2_pl_exu_wbck.sv
`default_nettype none
// Bench for cl2_pl_exu_wbck: directed + random stimulus, expected writes queued
// and checked by an independent monitor on the regfile write port.
module tb_cl2_pl_exu_wbck;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_vld = 1'b0, lsu_vld = 1'b0, mdu_vld = 1'b0, iss_vld = 1'b0;
  logic [AW-1:0]   alu_idx = '0, lsu_idx = '0, mdu_idx = '0, iss_idx = '0;
  logic [AW-1:0]   rs1_idx = '0, rs2_idx = '0;
  logic [XLEN-1:0] alu_dat = '0, lsu_dat = '0, mdu_dat = '0;
  logic            lsu_rdy, mdu_rdy, rs1_busy, rs2_busy, rs1_fwd_vld, rs2_fwd_vld, wd_wen;
  logic [XLEN-1:0] rs1_fwd_dat, rs2_fwd_dat, wd_dat;
  logic [AW-1:0]   wd_idx;

  cl2_pl_exu_wbck dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .alu_vld_i(alu_vld), .alu_idx_i(alu_idx), .alu_dat_i(alu_dat),
    .lsu_vld_i(lsu_vld), .lsu_rdy_o(lsu_rdy), .lsu_idx_i(lsu_idx), .lsu_dat_i(lsu_dat),
    .mdu_vld_i(mdu_vld), .mdu_rdy_o(mdu_rdy), .mdu_idx_i(mdu_idx), .mdu_dat_i(mdu_dat),
    .iss_vld_i(iss_vld), .iss_idx_i(iss_idx),
    .rs1_idx_i(rs1_idx), .rs2_idx_i(rs2_idx),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .rs1_fwd_vld_o(rs1_fwd_vld), .rs1_fwd_dat_o(rs1_fwd_dat),
    .rs2_fwd_vld_o(rs2_fwd_vld), .rs2_fwd_dat_o(rs2_fwd_dat),
    .wd_wen_o(wd_wen), .wd_idx_o(wd_idx), .wd_dat_o(wd_dat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] dat;
  } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference state: pending destinations and the last retired write.
  bit              pend_m[32];
  bit              lw_v = 1'b0;
  logic [AW-1:0]   lw_i = '0;
  logic [XLEN-1:0] lw_d = '0;
  int              last_w = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input logic [AW-1:0] idx);
`ifdef CL2_WBCK_BYPASS_EN
    return (idx != 0) && pend_m[idx];
`else
    return (idx != 0) && (pend_m[idx] || (lw_v && lw_i == idx));
`endif
  endfunction

  function automatic bit exp_fwd(input logic [AW-1:0] idx);
    return (idx != 0) && lw_v && lw_i == idx;
  endfunction

  task automatic model_clear();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    lw_v = 1'b0;
    lw_i = '0;
    lw_d = '0;
    exp_q.delete();
  endtask

  // One cycle: inputs already driven at posedge+1; check at negedge, advance model.
  task automatic step();
    int              w;
    logic [AW-1:0]   wi;
    logic [XLEN-1:0] wdt;
    w = alu_vld ? 1 : (lsu_vld ? 2 : (mdu_vld ? 3 : 0));
    wi = (w == 1) ? alu_idx : (w == 2) ? lsu_idx : mdu_idx;
    wdt = (w == 1) ? alu_dat : (w == 2) ? lsu_dat : mdu_dat;
    @(negedge clk);
    chk("lsu_rdy", lsu_rdy, w == 2);
    chk("mdu_rdy", mdu_rdy, w == 3);
    chk("rs1_busy", rs1_busy, exp_busy(rs1_idx));
    chk("rs2_busy", rs2_busy, exp_busy(rs2_idx));
`ifdef CL2_WBCK_BYPASS_EN
    chk("rs1_fwd_vld", rs1_fwd_vld, exp_fwd(rs1_idx));
    chk("rs2_fwd_vld", rs2_fwd_vld, exp_fwd(rs2_idx));
    if (exp_fwd(rs1_idx)) chk("rs1_fwd_dat", rs1_fwd_dat, lw_d);
    if (exp_fwd(rs2_idx)) chk("rs2_fwd_dat", rs2_fwd_dat, lw_d);
`else
    chk("rs1_fwd_vld", rs1_fwd_vld, 0);
    chk("rs2_fwd_dat", rs2_fwd_dat, 0);
`endif
    if (w != 0 && wi != 0) exp_q.push_back('{cyc + 1, wi, wdt});
    if (w == 2 || w == 3) pend_m[wi] = 1'b0;
    if (iss_vld && iss_idx != 0) pend_m[iss_idx] = 1'b1;
    lw_v = (w != 0) && (wi != 0);
    if (w != 0) begin
      lw_i = wi;
      lw_d = wdt;
    end
    last_w = w;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write on the port must match the oldest expected write, on time.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wd_wen) begin
          if (exp_q.size() == 0) chk("wr_unexpected", wd_wen, 0);
          else begin
            e = exp_q.pop_front();
            chk("wr_idx", wd_idx, e.idx);
            chk("wr_dat", wd_dat, e.dat);
            chk("wr_cyc", cyc, e.cyc);
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("wr_missing", wd_wen, 1);
          e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rs1_idx = 5'd3;
    rs2_idx = 5'd9;
    #12;
    chk("rst_wen", wd_wen, 0);
    chk("rst_idx", wd_idx, 0);
    chk("rst_dat", wd_dat, 0);
    chk("rst_busy1", rs1_busy, 0);
    chk("rst_fwd2", rs2_fwd_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU write.
    alu_vld = 1; alu_idx = 5; alu_dat = 32'hDEADBEEF;
    step();
    alu_vld = 0;

    // All three sources at once drain in priority order.
    alu_vld = 1; alu_idx = 5'd1; alu_dat = 32'h0000_00A1;
    lsu_vld = 1; lsu_idx = 5'd6; lsu_dat = 32'h0000_0B06;
    mdu_vld = 1; mdu_idx = 5'd7; mdu_dat = 32'h0000_0C07;
    step(); alu_vld = 0;
    step(); lsu_vld = 0;
    step(); mdu_vld = 0;
    step();

    // Long-latency destination stays busy until its LSU result is accepted.
    iss_vld = 1; iss_idx = 5'd9; rs1_idx = 5'd9;
    step(); iss_vld = 0;
    repeat (3) step();
    lsu_vld = 1; lsu_idx = 5'd9; lsu_dat = 32'h0999_0009;
    step(); lsu_vld = 0;
    step(); step();

    // Same-cycle issue and MDU retire on idx 3: pending survives.
    iss_vld = 1; iss_idx = 5'd3; mdu_vld = 1; mdu_idx = 5'd3; mdu_dat = 32'h3333;
    rs2_idx = 5'd3;
    step(); iss_vld = 0; mdu_vld = 0;
    step();
    mdu_vld = 1; mdu_dat = 32'h3334;
    step(); mdu_vld = 0;
    step(); step();

    // Writes and issues to x0 are ignored.
    alu_vld = 1; alu_idx = 0; alu_dat = 32'h1111;
    step(); alu_vld = 0;
    lsu_vld = 1; lsu_idx = 0; lsu_dat = 32'h2222;
    iss_vld = 1; iss_idx = 0; rs1_idx = 0;
    step(); lsu_vld = 0; iss_vld = 0;
    step();

    // Freshly written register seen through bypass or as a one-cycle stall.
    alu_vld = 1; alu_idx = 5'd4; alu_dat = 32'h1234;
    step(); alu_vld = 0; rs2_idx = 5'd4;
    step(); step();

    // Random traffic; LSU/MDU hold their payload until accepted.
    for (int i = 0; i < 400; i++) begin
      alu_vld = ($urandom_range(0, 3) == 0);
      alu_idx = AW'($urandom_range(0, 7));
      alu_dat = $urandom;
      if (!lsu_vld && $urandom_range(0, 2) == 0) begin
        lsu_vld = 1; lsu_idx = AW'($urandom_range(0, 7)); lsu_dat = $urandom;
      end
      if (!mdu_vld && $urandom_range(0, 3) == 0) begin
        mdu_vld = 1; mdu_idx = AW'($urandom_range(0, 7)); mdu_dat = $urandom;
      end
      iss_vld = ($urandom_range(0, 2) == 0);
      iss_idx = AW'($urandom_range(0, 7));
      rs1_idx = AW'($urandom_range(0, 7));
      rs2_idx = AW'($urandom_range(0, 7));
      step();
      if (last_w == 2) lsu_vld = 0;
      if (last_w == 3) mdu_vld = 0;
    end
    alu_vld = 0; lsu_vld = 0; mdu_vld = 0; iss_vld = 0;
    repeat (3) step();

    // Asynchronous reset with a pending destination and a write in flight.
    iss_vld = 1; iss_idx = 5'd2; rs1_idx = 5'd2;
    step(); iss_vld = 0;
    alu_vld = 1; alu_idx = 5'd8; alu_dat = 32'hCAFE;
    step(); alu_vld = 0;
    chk("inflight_wen", wd_wen, 1);
    chk("inflight_busy", rs1_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", wd_wen, 0);
    chk("arst_busy", rs1_busy, 0);
    chk("arst_idx", wd_idx, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(); step();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
